// File: rtl/rcu_div_bank_if.sv
// Configuration request channel of the RCU clock-divider bank.
// The slave side is the divider bank; the master is the RCU register file.
interface rcu_div_bank_if #(
  parameter int CH_NUM    = 4,
  parameter int DIV_WIDTH = 8
);
  localparam int CH_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [CH_W-1:0]      cfg_ch;
  logic                 cfg_en;
  logic [DIV_WIDTH-1:0] cfg_div;
  logic                 cfg_err;

  modport master (
    output cfg_valid, cfg_ch, cfg_en, cfg_div,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_en, cfg_div,
    output cfg_ready, cfg_err
  );
endinterface

// File: rtl/rcu_div_bank.sv
// N-channel programmable clock-divider bank with per-channel reset release.
// Reconfiguration is deferred to the next period boundary so outputs never glitch.
module rcu_div_bank #(
  parameter int CH_NUM      = 4,
  parameter int DIV_WIDTH   = 8,
  parameter int RST_DLY     = 4,
  parameter int DIV_RST_VAL = 3
) (
  input  logic                clk_i,
  input  logic                rst_i,
  rcu_div_bank_if.slave       cfg,
  output logic [CH_NUM-1:0]   div_clk_o,
  output logic [CH_NUM-1:0]   rst_n_o,
  output logic [CH_NUM-1:0]   done_o
);

  localparam int CH_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam int BC_W = $clog2(RST_DLY + 1);
  localparam logic [CH_W:0]      CH_LIM = (CH_W+1)'(CH_NUM);
  localparam logic [BC_W-1:0]    BC_MAX = BC_W'(RST_DLY);
  localparam logic [DIV_WIDTH-1:0] DIV_INIT = DIV_WIDTH'(DIV_RST_VAL);

  typedef enum logic [1:0] {IDLE, WARM, RUN, PEND} state_t;

  function automatic logic [DIV_WIDTH-1:0] clamp_div(input logic [DIV_WIDTH-1:0] d);
    return (d == '0) ? DIV_WIDTH'(1) : d;
  endfunction

  function automatic logic [BC_W-1:0] sat_inc(input logic [BC_W-1:0] b);
    return (b >= BC_MAX) ? b : b + 1'b1;
  endfunction

  logic [CH_NUM-1:0] pend;
  logic              ch_ok;
  logic              accept;

  assign ch_ok  = {1'b0, cfg.cfg_ch} < CH_LIM;
  assign accept = cfg.cfg_valid && cfg.cfg_ready;

  // Only a valid channel holding a deferred request can stall the bus.
  always_comb begin
    cfg.cfg_ready = 1'b1;
    for (int i = 0; i < CH_NUM; i++) begin
      if (cfg.cfg_ch == CH_W'(i) && pend[i]) cfg.cfg_ready = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cfg.cfg_err <= 1'b0;
    else       cfg.cfg_err <= accept && !ch_ok;
  end

  for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
    state_t               state_q;
    logic [DIV_WIDTH-1:0] cnt_q;
    logic [DIV_WIDTH-1:0] div_q;
    logic [DIV_WIDTH-1:0] pdiv_q;
    logic                 pen_q;
    logic [BC_W-1:0]      bcnt_q;
    logic                 clk_q;
    logic                 rstn_q;
    logic                 done_q;

    logic                 acc_ch;
    logic                 boundary;
    logic [BC_W-1:0]      bnext;
    logic                 rel;
    logic                 apply_vld;
    logic                 apply_en;
    logic [DIV_WIDTH-1:0] apply_div;
    logic [DIV_WIDTH-1:0] cnt_inc;

    assign acc_ch    = accept && (cfg.cfg_ch == CH_W'(g));
    assign boundary  = (cnt_q == div_q);
    assign bnext     = sat_inc(bcnt_q);
    assign rel       = rstn_q || (bnext >= BC_MAX);
    assign apply_vld = (state_q == PEND) || acc_ch;
    assign apply_en  = (state_q == PEND) ? pen_q  : cfg.cfg_en;
    assign apply_div = (state_q == PEND) ? pdiv_q : clamp_div(cfg.cfg_div);
    assign cnt_inc   = cnt_q + 1'b1;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        div_q   <= DIV_INIT;
        pen_q   <= 1'b0;
        bcnt_q  <= '0;
        clk_q   <= 1'b0;
        rstn_q  <= 1'b0;
        done_q  <= 1'b0;
      end else begin
        done_q <= 1'b0;
        case (state_q)
          IDLE: begin
            if (acc_ch && cfg.cfg_en) begin
              div_q   <= clamp_div(cfg.cfg_div);
              cnt_q   <= '0;
              bcnt_q  <= '0;
              clk_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= WARM;
            end
          end
          default: begin
            if (boundary) begin
              cnt_q  <= '0;
              clk_q  <= 1'b1;
              bcnt_q <= bnext;
              if (apply_vld && !apply_en) begin
                state_q <= IDLE;
                clk_q   <= 1'b0;
                rstn_q  <= 1'b0;
                bcnt_q  <= '0;
                done_q  <= 1'b1;
              end else begin
                rstn_q  <= rel;
                state_q <= rel ? RUN : WARM;
                if (apply_vld) begin
                  div_q  <= apply_div;
                  done_q <= 1'b1;
                end
              end
            end else begin
              cnt_q <= cnt_inc;
              clk_q <= (cnt_inc <= (div_q >> 1));
              // Mid-period requests wait here until the boundary.
              if (acc_ch) begin
                pen_q   <= cfg.cfg_en;
                pdiv_q  <= clamp_div(cfg.cfg_div);
                state_q <= PEND;
              end
            end
          end
        endcase
      end
    end

    assign pend[g]      = (state_q == PEND);
    assign div_clk_o[g] = clk_q;
    assign rst_n_o[g]   = rstn_q;
    assign done_o[g]    = done_q;
  end

endmodule

// File: tb/tb_rcu_div_bank.sv
// Directed bench for rcu_div_bank: start-up, reconfigure, disable, clamp, error,
// no-op and mid-run reset, three channels with RST_DLY=2.
module tb_rcu_div_bank;
  localparam int CH_NUM    = 3;
  localparam int DIV_WIDTH = 8;
  localparam int RST_DLY   = 2;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [CH_NUM-1:0] div_clk_o;
  logic [CH_NUM-1:0] rst_n_o;
  logic [CH_NUM-1:0] done_o;

  int n_assert = 0;
  int n_fail   = 0;

  rcu_div_bank_if #(.CH_NUM(CH_NUM), .DIV_WIDTH(DIV_WIDTH)) cfg_if ();

  rcu_div_bank #(
    .CH_NUM(CH_NUM), .DIV_WIDTH(DIV_WIDTH), .RST_DLY(RST_DLY), .DIV_RST_VAL(3)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .cfg       (cfg_if.slave),
    .div_clk_o (div_clk_o),
    .rst_n_o   (rst_n_o),
    .done_o    (done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drv(input logic v, input logic [1:0] ch, input logic en, input logic [7:0] dv);
    cfg_if.cfg_valid = v;
    cfg_if.cfg_ch    = ch;
    cfg_if.cfg_en    = en;
    cfg_if.cfg_div   = dv;
  endtask

  task automatic chk(input string tag, input int cyc, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s @cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  initial begin
    logic [2:0] e_clk, e_rst, e_done;
    logic       e_rdy;

    rst_i = 1'b1;
    drv(1'b0, 2'd0, 1'b0, 8'd0);
    tick();
    tick();
    chk("rst_div_clk", -1, 8'(div_clk_o), 8'h0);
    chk("rst_rst_n",   -1, 8'(rst_n_o),   8'h0);
    chk("rst_done",    -1, 8'(done_o),    8'h0);
    chk("rst_err",     -1, 8'(cfg_if.cfg_err),   8'h0);
    chk("rst_ready",   -1, 8'(cfg_if.cfg_ready), 8'h1);
    rst_i = 1'b0;

    for (int c = 0; c <= 50; c++) begin
      case (c)
        0:  drv(1'b1, 2'd0, 1'b1, 8'd3);
        1:  drv(1'b0, 2'd0, 1'b0, 8'd0);
        14: drv(1'b1, 2'd0, 1'b1, 8'd4);
        15: drv(1'b1, 2'd0, 1'b1, 8'd7);
        16: begin
          drv(1'b1, 2'd0, 1'b1, 8'd7);
          #1;
          chk("pend_stall_ch0", c, 8'(cfg_if.cfg_ready), 8'h0);
          drv(1'b1, 2'd1, 1'b1, 8'd5);
        end
        17: drv(1'b0, 2'd0, 1'b0, 8'd0);
        23: drv(1'b1, 2'd1, 1'b0, 8'd0);
        24: drv(1'b0, 2'd1, 1'b0, 8'd0);
        36: drv(1'b1, 2'd2, 1'b1, 8'd0);
        37: drv(1'b0, 2'd2, 1'b0, 8'd0);
        42: drv(1'b1, 2'd3, 1'b1, 8'd9);
        43: drv(1'b1, 2'd1, 1'b0, 8'd0);
        44: drv(1'b0, 2'd1, 1'b0, 8'd0);
        50: drv(1'b1, 2'd0, 1'b1, 8'd2);
        default: ;
      endcase
      #1;
      e_clk[0]  = (c == 0) ? 1'b0 : (c <= 16) ? (((c - 1) % 4) < 2) : (((c - 17) % 5) < 3);
      e_clk[1]  = (c >= 17 && c <= 28) ? (((c - 17) % 6) < 3) : 1'b0;
      e_clk[2]  = (c >= 37) ? (((c - 37) % 2) == 0) : 1'b0;
      e_rst     = {c >= 41, 1'b0, c >= 9};
      e_done    = {c == 37, (c == 17 || c == 29), (c == 1 || c == 17)};
      e_rdy     = !((cfg_if.cfg_ch == 2'd0 && c == 15) ||
                    (cfg_if.cfg_ch == 2'd1 && c >= 24 && c <= 28));
      chk("div_clk", c, 8'(div_clk_o), 8'(e_clk));
      chk("rst_n",   c, 8'(rst_n_o),   8'(e_rst));
      chk("done",    c, 8'(done_o),    8'(e_done));
      chk("cfg_err", c, 8'(cfg_if.cfg_err), 8'(c == 43));
      chk("ready",   c, 8'(cfg_if.cfg_ready), 8'(e_rdy));
      if (c < 50) tick();
    end

    // ch0 now holds a deferred request; reset lands while it is pending.
    tick();
    chk("pend_before_rst", 51, 8'(cfg_if.cfg_ready), 8'h0);
    drv(1'b0, 2'd0, 1'b0, 8'd0);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("midrst_div_clk", 52, 8'(div_clk_o), 8'h0);
    chk("midrst_rst_n",   52, 8'(rst_n_o),   8'h0);
    chk("midrst_done",    52, 8'(done_o),    8'h0);
    chk("midrst_ready",   52, 8'(cfg_if.cfg_ready), 8'h1);
    drv(1'b1, 2'd0, 1'b1, 8'd3);
    tick();
    drv(1'b0, 2'd0, 1'b0, 8'd0);
    chk("reen_done", 53, 8'(done_o), 8'h1);
    for (int k = 0; k < 4; k++) begin
      chk("reen_div_clk", 53 + k, 8'(div_clk_o), (k < 2) ? 8'h1 : 8'h0);
      chk("reen_rst_n",   53 + k, 8'(rst_n_o),   8'h0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
